// File: rtl/amux_rr_n_pkg.sv
// amux_pkg: arbitration mode encoding and counter width shared by the amux_rr_n slice
package amux_pkg;
  typedef enum logic [1:0] {
    AMUX_RR        = 2'b00,
    AMUX_FIXED     = 2'b01,
    AMUX_FORCE     = 2'b10,
    AMUX_FORCE_ALT = 2'b11
  } amux_mode_e;
  localparam int AMUX_CNT_W = 16;
endpackage

// File: rtl/amux_rr_n_pick.sv
// amux_rr_pick: combinational winner selection for round-robin, fixed-priority and forced modes
module amux_rr_pick
  import amux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] valid,
  input  logic [SELW-1:0] rr_ptr,
  input  amux_mode_e      mode,
  input  logic [SELW-1:0] force_sel,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);
  logic            rr_v, fx_v, fc_v;
  logic [SELW-1:0] rr_i, fx_i, fc_i;
  // scan downwards so the candidate nearest the start of each search order wins
  always_comb begin
    rr_v = 1'b0;
    rr_i = '0;
    fx_v = 1'b0;
    fx_i = '0;
    fc_v = 1'b0;
    fc_i = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (valid[(int'(rr_ptr) + k) % N_CH]) begin
        rr_v = 1'b1;
        rr_i = SELW'((int'(rr_ptr) + k) % N_CH);
      end
      if (valid[k]) begin
        fx_v = 1'b1;
        fx_i = SELW'(k);
      end
      if (valid[k] && force_sel == SELW'(k)) begin
        fc_v = 1'b1;
        fc_i = SELW'(k);
      end
    end
  end
  assign gnt_vld = mode == AMUX_RR ? rr_v : mode == AMUX_FIXED ? fx_v : fc_v;
  assign gnt_idx = mode == AMUX_RR ? rr_i : mode == AMUX_FIXED ? fx_i : fc_i;
endmodule

// File: rtl/amux_rr_n.sv
// amux_rr_n: N:1 arbitrated mux with registered output; AMUX_STATS_EN adds saturating per-channel grant counters
module amux_rr_n
  import amux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 32,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  amux_mode_e                 amux_i_mode,
  input  logic [SELW-1:0]            amux_i_force_sel,
  input  logic [N_CH-1:0]            amux_i_valid,
  input  logic [N_CH*DW-1:0]         amux_i_data,
  output logic [N_CH-1:0]            amux_o_ready,
  output logic                       amux_o_valid,
  output logic [DW-1:0]              amux_o_data,
  output logic [SELW-1:0]            amux_o_sel,
  input  logic                       amux_i_ready,
  output logic [N_CH*AMUX_CNT_W-1:0] amux_o_grant_cnt
);
  logic            load_en, gnt_vld, take;
  logic [SELW-1:0] gnt_idx, rr_ptr;
  amux_rr_pick #(.N_CH(N_CH), .SELW(SELW)) u_pick (
    .valid    (amux_i_valid),
    .rr_ptr   (rr_ptr),
    .mode     (amux_i_mode),
    .force_sel(amux_i_force_sel),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );
  assign load_en      = !amux_o_valid || amux_i_ready;
  assign take         = i_rst_n && load_en && gnt_vld;
  assign amux_o_ready = take ? N_CH'(1) << gnt_idx : '0;
  // output stage reloads whenever it is empty or draining; rr pointer advances past each RR winner
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      amux_o_valid <= 1'b0;
      amux_o_data  <= '0;
      amux_o_sel   <= '0;
      rr_ptr       <= '0;
    end else if (load_en) begin
      amux_o_valid <= gnt_vld;
      if (gnt_vld) begin
        amux_o_data <= amux_i_data[gnt_idx*DW +: DW];
        amux_o_sel  <= gnt_idx;
        if (amux_i_mode == AMUX_RR) rr_ptr <= gnt_idx == SELW'(N_CH - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
`ifdef AMUX_STATS_EN
  logic [AMUX_CNT_W-1:0] cnt [N_CH];
  // saturating grant counters, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) if (amux_o_ready[k] && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
    end
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_cnt
    assign amux_o_grant_cnt[k*AMUX_CNT_W +: AMUX_CNT_W] = cnt[k];
  end
`else
  assign amux_o_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_amux_rr_n.sv
// tb_amux_rr_n: randomized scoreboard bench for amux_rr_n against a queue-based reference model
module tb_amux_rr_n;
  import amux_pkg::*;
  localparam int N  = 4;
  localparam int DW = 32;
`ifdef AMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic            clk = 1'b0, rst_n = 1'b0, irdy = 1'b0;
  amux_mode_e      mode = AMUX_RR;
  logic [1:0]      fsel = '0;
  logic [N-1:0]    vld = '0;
  logic [N*DW-1:0] din = '0;
  logic [N-1:0]    ordy;
  logic            oval;
  logic [DW-1:0]   odat;
  logic [1:0]      osel;
  logic [N*16-1:0] gcnt;
  int              errs = 0, checks = 0, mptr = 0;
  int              mcnt [N];
  bit              chk_en = 1'b0;
  logic [N-1:0]    exp_rdy = '0;
  logic [DW+1:0]   q [$];
  always #5 clk = ~clk;
  amux_rr_n #(.N_CH(N), .DW(DW)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .amux_i_mode     (mode),
    .amux_i_force_sel(fsel),
    .amux_i_valid    (vld),
    .amux_i_data     (din),
    .amux_o_ready    (ordy),
    .amux_o_valid    (oval),
    .amux_o_data     (odat),
    .amux_o_sel      (osel),
    .amux_i_ready    (irdy),
    .amux_o_grant_cnt(gcnt)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [N*DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic void pick(input logic [1:0] md, input logic [1:0] fs, input logic [3:0] vl,
                               input int ptr, output bit gv, output int g);
    int c;
    gv = 1'b0;
    g  = 0;
    for (int k = 0; k < N; k++) begin
      c = md == 2'd0 ? (ptr + k) % N : md == 2'd1 ? k : int'(fs);
      if (!gv && vl[c]) begin
        gv = 1'b1;
        g  = c;
      end
    end
  endfunction
  task automatic step(input logic [1:0] md, input logic [1:0] fs, input logic [3:0] vl,
                      input logic rdy, input logic [N*DW-1:0] d);
    bit gv;
    int g;
    mode = amux_mode_e'(md);
    fsel = fs;
    vld  = vl;
    irdy = rdy;
    din  = d;
    pick(md, fs, vl, mptr, gv, g);
    gv      = gv && (q.size() == 0 || rdy);
    exp_rdy = gv ? 4'(1 << g) : '0;
    @(posedge clk);
    if (gv) begin
      q.push_back({d[g*DW +: DW], 2'(g)});
      if (md == 2'd0) mptr = (g + 1) % N;
      if (mcnt[g] < 65535) mcnt[g]++;
    end
    #1;
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 64'(ordy), 64'(exp_rdy));
      chk("valid", 64'(oval), 64'(q.size() != 0));
      if (q.size() != 0) begin
        if (oval) begin
          chk("data", 64'(odat), 64'(q[0][DW+1:2]));
          chk("sel", 64'(osel), 64'(q[0][1:0]));
        end
        if (irdy) void'(q.pop_front());
      end
    end
  end
  task automatic do_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    vld    = 4'hF;
    irdy   = 1'b1;
    din    = rnd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(oval), 64'd0);
    chk("rst_ready", 64'(ordy), 64'd0);
    chk("rst_data", 64'(odat), 64'd0);
    chk("rst_sel", 64'(osel), 64'd0);
    chk("rst_cnt", 64'(gcnt[15:0]), 64'd0);
    q.delete();
    mptr = 0;
    for (int k = 0; k < N; k++) mcnt[k] = 0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask
  initial begin
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) mcnt[k] = 0;
    do_reset();
    repeat (6) step(2'd0, 2'd0, 4'hF, 1'b1, rnd());
    repeat (4) step(2'd1, 2'd0, 4'b1010, 1'b1, rnd());
    step(2'd1, 2'd0, 4'b1000, 1'b1, rnd());
    repeat (3) step(2'd2, 2'd2, 4'b0100, 1'b1, rnd());
    repeat (2) step(2'd2, 2'd2, 4'b0011, 1'b1, rnd());
    step(2'd3, 2'd1, 4'b0011, 1'b1, rnd());
    d = rnd();
    d[31:0] = 32'hDEAD_BEEF;
    step(2'd1, 2'd0, 4'b0001, 1'b1, d);
    repeat (4) step(2'd0, 2'd0, 4'hF, 1'b0, rnd());
    repeat (2) step(2'd0, 2'd0, 4'hF, 1'b1, rnd());
    step(2'd1, 2'd0, 4'b0010, 1'b0, rnd());
    step(2'd1, 2'd0, 4'b0010, 1'b0, rnd());
    do_reset();
    step(2'd0, 2'd0, 4'hF, 1'b1, rnd());
    repeat (3000)
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom),
           1'($urandom_range(0, 3) != 0), rnd());
`ifdef AMUX_STATS_EN
    repeat (70000) step(2'd1, 2'd0, 4'b0001, 1'b1, rnd());
`endif
    step(2'd0, 2'd0, 4'h0, 1'b1, rnd());
    @(negedge clk);
    for (int k = 0; k < N; k++) chk("grant_cnt", 64'(gcnt[k*16 +: 16]), STATS ? 64'(mcnt[k]) : 64'd0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
